// File: rtl/m14k_mbist_ctl.sv
// m14k_mbist_ctl: March C- memory BIST controller for up to NCH single-port SRAM channels.
//
// Channels selected by bist_chmask are tested one after another, in ascending index
// order, over a shared address/write-data bus. Each channel gets the sequence
// M0 up w0, M1 up (r0,w1), M2 up (r1,w0), M3 down (r0,w1), M4 down (r1,w0), M5 up r0,
// which takes 10*DEPTH cycles. Read data is compared one cycle after the read access.
//
// Ports:
//   gclk, greset_n         clock, synchronous active-low reset
//   bist_start             start pulse, accepted in IDLE or DONE
//   bist_mode              data background: 0 solid (0/all-ones), 1 checkerboard (55../AA..)
//   bist_chmask            channels to test, sampled with an accepted start
//   bist_busy, bist_done   test in progress / test finished (level)
//   bist_fail              sticky per-channel miscompare flags
//   bist_fail_ch/_addr     channel and address of the first miscompare
//   mb_en, mb_we           one-hot array enable, write strobe
//   mb_addr, mb_wdata      array address and write data
//   mb_rdata               read data, channel c at [c*DW +: DW], one cycle after the read
module m14k_mbist_ctl #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CHW   = 2,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 32
) (
    input  logic              gclk,
    input  logic              greset_n,
    input  logic              bist_start,
    input  logic              bist_mode,
    input  logic [NCH-1:0]    bist_chmask,
    output logic              bist_busy,
    output logic              bist_done,
    output logic [NCH-1:0]    bist_fail,
    output logic [CHW-1:0]    bist_fail_ch,
    output logic [AW-1:0]     bist_fail_addr,
    output logic [NCH-1:0]    mb_en,
    output logic              mb_we,
    output logic [AW-1:0]     mb_addr,
    output logic [DW-1:0]     mb_wdata,
    input  logic [NCH*DW-1:0] mb_rdata
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [2:0]      elem_q, elem_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            phase_q, phase_d;
    logic            cmp_vld_q, cmp_vld_d;
    logic [CHW-1:0]  cmp_ch_q, cmp_ch_d;
    logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
    logic [DW-1:0]   cmp_exp_q, cmp_exp_d;
    logic [NCH-1:0]  fail_q, fail_d;
    logic [CHW-1:0]  fail_ch_q, fail_ch_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;

    // Data backgrounds for logical 0 and logical 1 under the latched mode.
    logic [DW-1:0] pat_chk;
    logic [DW-1:0] bg0, bg1;

    always_comb begin
        pat_chk = '0;
        for (int i = 0; i < int'(DW); i += 2) begin
            pat_chk[i] = 1'b1;
        end
    end

    assign bg0 = mode_q ? pat_chk : '0;
    assign bg1 = mode_q ? ~pat_chk : '1;

    // March element decode. A pair element is read in phase 0, write in phase 1.
    logic is_pair, is_down, rd_val, wr_val;
    logic is_read, last_addr, step_end;

    always_comb begin
        is_pair = 1'b0;
        is_down = 1'b0;
        rd_val  = 1'b0;
        wr_val  = 1'b0;
        case (elem_q)
            3'd1:    {is_pair, is_down, rd_val, wr_val} = 4'b1001;
            3'd2:    {is_pair, is_down, rd_val, wr_val} = 4'b1010;
            3'd3:    {is_pair, is_down, rd_val, wr_val} = 4'b1101;
            3'd4:    {is_pair, is_down, rd_val, wr_val} = 4'b1110;
            default: {is_pair, is_down, rd_val, wr_val} = 4'b0000;
        endcase
        is_read   = (elem_q == 3'd5) || (is_pair && !phase_q);
        last_addr = is_down ? (addr_q == '0) : (addr_q == LastAddr);
        step_end  = !is_pair || phase_q;
    end

    // Lowest requested channel at start, and the next latched channel above the current one.
    logic [CHW-1:0] first_ch, next_ch;
    logic           first_vld, next_vld;

    always_comb begin
        first_ch  = '0;
        first_vld = 1'b0;
        next_ch   = '0;
        next_vld  = 1'b0;
        for (int c = int'(NCH) - 1; c >= 0; c--) begin
            if (bist_chmask[c]) begin
                first_ch  = CHW'(c);
                first_vld = 1'b1;
            end
            if (mask_q[c] && (c > int'(ch_q))) begin
                next_ch  = CHW'(c);
                next_vld = 1'b1;
            end
        end
    end

    // Read data of the channel captured with the read, not the channel currently driven.
    logic [DW-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (cmp_ch_q == CHW'(c)) begin
                rd_sel = mb_rdata[c*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        cmp_vld_d   = 1'b0;
        cmp_ch_d    = cmp_ch_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_exp_d   = cmp_exp_q;
        fail_d      = fail_q;
        fail_ch_d   = fail_ch_q;
        fail_addr_d = fail_addr_q;

        if (cmp_vld_q && (rd_sel != cmp_exp_q)) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (cmp_ch_q == CHW'(c)) begin
                    fail_d[c] = 1'b1;
                end
            end
            if (fail_q == '0) begin
                fail_ch_d   = cmp_ch_q;
                fail_addr_d = cmp_addr_q;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (bist_start) begin
                    mode_d      = bist_mode;
                    mask_d      = bist_chmask;
                    fail_d      = '0;
                    fail_ch_d   = '0;
                    fail_addr_d = '0;
                    ch_d        = first_ch;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    state_d     = first_vld ? StRun : StDrain;
                end
            end
            StRun: begin
                if (is_read) begin
                    cmp_vld_d  = 1'b1;
                    cmp_ch_d   = ch_q;
                    cmp_addr_d = addr_q;
                    cmp_exp_d  = rd_val ? bg1 : bg0;
                end
                if (!step_end) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = is_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                    end else if (elem_q == 3'd5) begin
                        elem_d = 3'd0;
                        addr_d = '0;
                        if (next_vld) begin
                            ch_d = next_ch;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        elem_d = elem_q + 3'd1;
                        // M3 and M4 run downwards.
                        addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LastAddr : '0;
                    end
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mb_en    = '0;
        mb_we    = 1'b0;
        mb_addr  = '0;
        mb_wdata = '0;
        if (state_q == StRun) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (ch_q == CHW'(c)) begin
                    mb_en[c] = 1'b1;
                end
            end
            mb_addr = addr_q;
            mb_we   = !is_read;
            if (!is_read) begin
                mb_wdata = wr_val ? bg1 : bg0;
            end
        end
    end

    assign bist_busy      = (state_q == StRun) || (state_q == StDrain);
    assign bist_done      = (state_q == StDone);
    assign bist_fail      = fail_q;
    assign bist_fail_ch   = fail_ch_q;
    assign bist_fail_addr = fail_addr_q;

    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            ch_q        <= '0;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_ch_q    <= '0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            fail_q      <= '0;
            fail_ch_q   <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_ch_q    <= cmp_ch_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            fail_q      <= fail_d;
            fail_ch_q   <= fail_ch_d;
            fail_addr_q <= fail_addr_d;
        end
    end

endmodule
